// File: rtl/time_adjust_ctrl.sv
// Front-panel adjust controller: synchronised/debounced buttons drive a
// RUN / ADJ_H / ADJ_M mode FSM that emits hour/minute step pulses.

module time_adjust_ctrl_btn #(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic lvl
);
  localparam int CW = $clog2(DB_CYCLES + 1);

  logic          s1, s2;
  logic [CW-1:0] cnt;

  // Level flips on the DB_CYCLES-th consecutive disagreeing sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      lvl <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == lvl) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CYCLES - 1)) begin
        lvl <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module time_adjust_ctrl #(
  parameter int DB_CYCLES      = 1_000_000,
  parameter int REPEAT_CYCLES  = 25_000_000,
  parameter int TIMEOUT_CYCLES = 1_000_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btnC,
  input  logic       btnL,
  input  logic       btnR,
  input  logic       btnU,
  input  logic       btnD,
  output logic       adjust,
  output logic       ENTH,
  output logic       ENTM,
  output logic       updown,
  output logic [1:0] mode
);
  localparam int NB = 5;
  localparam int B_C = 0, B_L = 1, B_R = 2, B_U = 3, B_D = 4;
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {RUN = 2'b00, ADJ_H = 2'b01, ADJ_M = 2'b10} state_t;

  logic [NB-1:0] raw, lvl, lvl_d, press;
  state_t        state, state_n;
  logic          adjust_q, enth_q, entm_q, updown_q;
  logic          enth_n, entm_n, updown_n;
  logic          rpt_on, rpt_on_n, rpt_dn, rpt_dn_n, rpt_fire, held;
  logic [RW-1:0] rpt_cnt, rpt_cnt_n;
  logic [IW-1:0] idle_cnt, idle_n;
  logic          step, step_dn;

  assign raw = {btnD, btnU, btnR, btnL, btnC};

  for (genvar gi = 0; gi < NB; gi++) begin : g_btn
    time_adjust_ctrl_btn #(.DB_CYCLES(DB_CYCLES)) u_btn (
      .clk (clk),
      .rst (rst),
      .raw (raw[gi]),
      .lvl (lvl[gi])
    );
  end

  assign press = lvl & ~lvl_d;
  assign held  = rpt_dn ? lvl[B_D] : lvl[B_U];

  always_comb begin
    state_n   = state;
    enth_n    = 1'b0;
    entm_n    = 1'b0;
    updown_n  = updown_q;
    rpt_on_n  = rpt_on;
    rpt_dn_n  = rpt_dn;
    rpt_cnt_n = rpt_cnt;
    rpt_fire  = 1'b0;
    step      = 1'b0;
    step_dn   = 1'b0;
    idle_n    = (idle_cnt == IDLE_MAX) ? idle_cnt : idle_cnt + 1'b1;

    if (rpt_on) begin
      if (!held) begin
        rpt_on_n  = 1'b0;
        rpt_cnt_n = '0;
      end else if (rpt_cnt == RPT_LAST) begin
        rpt_fire  = 1'b1;
        rpt_cnt_n = '0;
      end else begin
        rpt_cnt_n = rpt_cnt + 1'b1;
      end
    end

    case (state)
      RUN: begin
        idle_n = '0;
        if (press[B_C]) state_n = ADJ_H;
      end
      default: begin
        // Highest-priority press class wins; the rest are dropped this cycle.
        if (press[B_C]) begin
          state_n = RUN;
        end else if (press[B_L] | press[B_R]) begin
          idle_n = '0;
          if (press[B_L] & ~press[B_R])      state_n = ADJ_H;
          else if (press[B_R] & ~press[B_L]) state_n = ADJ_M;
        end else if (press[B_U] | press[B_D]) begin
          idle_n    = '0;
          rpt_cnt_n = '0;
          if (press[B_U] ^ press[B_D]) begin
            step     = 1'b1;
            step_dn  = press[B_D];
            rpt_on_n = 1'b1;
            rpt_dn_n = press[B_D];
          end else begin
            rpt_on_n = 1'b0;
          end
        end else if (rpt_fire) begin
          idle_n  = '0;
          step    = 1'b1;
          step_dn = rpt_dn;
        end else if (idle_cnt == IDLE_MAX) begin
          state_n = RUN;
        end
      end
    endcase

    if (step) begin
      updown_n = step_dn;
      enth_n   = (state == ADJ_H);
      entm_n   = (state == ADJ_M);
    end

    if (state_n != state) begin
      rpt_on_n  = 1'b0;
      rpt_cnt_n = '0;
      idle_n    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RUN;
      lvl_d    <= '0;
      adjust_q <= 1'b0;
      enth_q   <= 1'b0;
      entm_q   <= 1'b0;
      updown_q <= 1'b0;
      rpt_on   <= 1'b0;
      rpt_dn   <= 1'b0;
      rpt_cnt  <= '0;
      idle_cnt <= '0;
    end else begin
      state    <= state_n;
      lvl_d    <= lvl;
      adjust_q <= (state_n != RUN);
      enth_q   <= enth_n;
      entm_q   <= entm_n;
      updown_q <= updown_n;
      rpt_on   <= rpt_on_n;
      rpt_dn   <= rpt_dn_n;
      rpt_cnt  <= rpt_cnt_n;
      idle_cnt <= idle_n;
    end
  end

  assign adjust = adjust_q;
  assign ENTH   = enth_q;
  assign ENTM   = entm_q;
  assign updown = updown_q;
  assign mode   = state;
endmodule
